// File: rtl/src_operand_sel.sv
// ---------------------------------------------------------------------------
// src_operand_sel
//
// Purpose:
//   Selects one of NUM_SRC packed operand sources (by convention 0=Rn, 1=Rs,
//   2=PC, 3=immediate), optionally replaces it with a writeback-forwarded
//   value, and presents the result through a single registered output stage.
//   An accepted select that does not name a real source loads zero, sets a
//   sticky error flag and bumps a saturating error counter.
//
// Optional feature:
//   Define SRC_FWD_EN to add the fwd_* ports and writeback forwarding.
//   With SRC_FWD_EN undefined the fwd_* ports do not exist and the selected
//   source is always loaded.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   src_in     in   NUM_SRC*DATA_W packed sources, source k at [k*DATA_W +: DATA_W]
//   select     in   SEL_W source index
//   in_valid   in   select/src_in valid this cycle
//   in_ready   out  stage can accept (combinational)
//   fwd_valid  in   forwarded value present           (SRC_FWD_EN only)
//   fwd_src    in   source index the value supersedes (SRC_FWD_EN only)
//   fwd_data   in   forwarded value                   (SRC_FWD_EN only)
//   src_out    out  registered selected operand
//   out_valid  out  src_out holds an operand
//   out_ready  in   consumer takes src_out this cycle
//   sel_err    out  sticky illegal-select flag (cleared only by reset)
//   err_count  out  saturating count of accepted illegal selects
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid && !ready; ready
// may depend combinationally on the downstream ready, never on valid.
// ---------------------------------------------------------------------------
module src_operand_sel #(
  parameter int DATA_W   = 32,
  parameter int NUM_SRC  = 4,
  parameter int SEL_W    = $clog2(NUM_SRC),
  parameter int ERRCNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_in,
  input  logic [SEL_W-1:0]          select,
  input  logic                      in_valid,
  output logic                      in_ready,
`ifdef SRC_FWD_EN
  input  logic                      fwd_valid,
  input  logic [SEL_W-1:0]          fwd_src,
  input  logic [DATA_W-1:0]         fwd_data,
`endif
  output logic [DATA_W-1:0]         src_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  output logic [ERRCNT_W-1:0]       err_count
);

  // Source count widened by one bit so the compare also works when NUM_SRC
  // is a power of two (every select encoding is then legal).
  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);

  logic              accept;
  logic              illegal;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] load_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign illegal  = ({1'b0, select} >= NUM_SRC_W);

  // Explicit compare-per-source mux: an illegal select matches nothing and
  // falls through to zero, which is exactly the value it must load.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (select == SEL_W'(k)) begin
        sel_data = src_in[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SRC_FWD_EN
  // Forwarded data replaces only the source it supersedes, and only for a
  // legal select; it is never stored for later use.
  always_comb begin
    load_data = sel_data;
    if (fwd_valid && (fwd_src == select) && !illegal) begin
      load_data = fwd_data;
    end
  end
`else
  assign load_data = sel_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      src_out   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        src_out   <= load_data;
        out_valid <= 1'b1;
        if (illegal) begin
          sel_err <= 1'b1;
          if (!(&err_count)) begin
            err_count <= err_count + 1'b1;
          end
        end
      end else if (out_valid && out_ready) begin
        // Drained with nothing new: src_out keeps its last value.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_src_operand_sel.sv
// ---------------------------------------------------------------------------
// tb_src_operand_sel
//
// Bench for src_operand_sel built with NUM_SRC=3 so select=3 is illegal.
// The driver pushes {data, sel_err, err_count} expectations when a request is
// accepted; a monitor pops and compares whenever an operand is consumed.
// Forwarding vectors are only issued when SRC_FWD_EN is defined.
// ---------------------------------------------------------------------------
module tb_src_operand_sel;

  localparam int DW = 32;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int EW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NS*DW-1:0] src_in;
  logic [SW-1:0]    select;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    src_out;
  logic             out_valid;
  logic             out_ready;
  logic             sel_err;
  logic [EW-1:0]    err_count;
`ifdef SRC_FWD_EN
  logic             fwd_valid;
  logic [SW-1:0]    fwd_src;
  logic [DW-1:0]    fwd_data;
`endif

  src_operand_sel #(
    .DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .ERRCNT_W(EW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .src_in(src_in),
    .select(select),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef SRC_FWD_EN
    .fwd_valid(fwd_valid),
    .fwd_src(fwd_src),
    .fwd_data(fwd_data),
`endif
    .src_out(src_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err(sel_err),
    .err_count(err_count)
  );

  // scoreboard
  logic [DW+EW:0] exp_q[$];
  logic           exp_err;
  logic [EW-1:0]  exp_cnt;
  int             checks = 0;
  int             errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present a request, push the expectation when it is accepted
  task automatic issue(input logic [SW-1:0] sel, input logic [DW-1:0] s0,
                       input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                       input logic [DW-1:0] exp_d);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    select   = sel;
    src_in   = {s2, s1, s0};
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (sel >= SW'(NS)) begin
          exp_err = 1'b1;
          if (exp_cnt != {EW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end
        exp_q.push_back({exp_d, exp_err, exp_cnt});
        done = 1;
      end else if (++n > 50) begin
        check("accept_timeout", 64'(n), 64'd0);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // monitor
  initial begin
    logic [DW+EW:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(src_out), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("src_out",   64'(src_out),   64'(e[DW+EW:EW+1]));
          check("sel_err",   64'(sel_err),   64'(e[EW]));
          check("err_count", 64'(err_count), 64'(e[EW-1:0]));
        end
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; src_in = '0; select = '0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef SRC_FWD_EN
    fwd_valid = 1'b0; fwd_src = '0; fwd_data = '0;
`endif
    exp_err = 1'b0; exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_src_out",   64'(src_out),   64'd0);
    check("rst_sel_err",   64'(sel_err),   64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    // basic select of source 2, then back-to-back legal selects
    out_ready = 1'b1;
    issue(2'd2, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0000_1000, 32'h0000_1000);
    issue(2'd0, 32'h1234_5678, 32'h8765_4321, 32'h0F0F_0F0F, 32'h1234_5678);
    issue(2'd1, 32'h1234_5678, 32'h8765_4321, 32'h0F0F_0F0F, 32'h8765_4321);
    issue(2'd2, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000);

    // drain with no new input: out_valid clears, src_out holds
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_src_out",   64'(src_out),   64'h8000_0000);
    @(posedge clk); #1;

    // stall: held operand survives new requests, then loads with no bubble
    out_ready = 1'b0;
    issue(2'd0, 32'hCAFE_0001, 32'h0, 32'h0, 32'hCAFE_0001);
    select = 2'd1; src_in = {32'h0, 32'hBEEF_0002, 32'h0}; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_src_out",   64'(src_out),   64'hCAFE_0001);
      check("stall_in_ready",  64'(in_ready),  64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(2'd1, 32'h0, 32'hBEEF_0002, 32'h0, 32'hBEEF_0002);
    in_valid = 1'b0;
    @(negedge clk);
    check("no_bubble_valid", 64'(out_valid), 64'd1);
    check("no_bubble_data",  64'(src_out),   64'hBEEF_0002);
    @(posedge clk); #1;

`ifdef SRC_FWD_EN
    // forwarding replaces only the matching legal source
    fwd_valid = 1'b1; fwd_src = 2'd0; fwd_data = 32'h22;
    issue(2'd0, 32'h11, 32'h33, 32'h44, 32'h22);
    fwd_src = 2'd1;
    issue(2'd0, 32'h11, 32'h33, 32'h44, 32'h11);
    fwd_src = 2'd2;
    issue(2'd2, 32'h11, 32'h33, 32'h44, 32'h22);
    fwd_valid = 1'b0;
    issue(2'd2, 32'h11, 32'h33, 32'h44, 32'h44);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
`endif

    // illegal select 300 times: zero data, sticky flag, counter saturates
    for (int i = 0; i < 300; i++) begin
      issue(2'd3, 32'hDEAD_0000 + i, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0);
    end
    issue(2'd1, 32'h0, 32'h7777_7777, 32'h0, 32'h7777_7777);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sat_err_count", 64'(err_count), 64'hFF);
    @(posedge clk); #1;

    // reset during a stall with sel_err set
    out_ready = 1'b0;
    issue(2'd2, 32'h0, 32'h0, 32'h9999_0000, 32'h9999_0000);
    select = 2'd3; in_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_sel_err",   64'(sel_err),   64'd1);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    exp_err = 1'b0; exp_cnt = '0;
    @(negedge clk);
    check("srst_out_valid", 64'(out_valid), 64'd0);
    check("srst_src_out",   64'(src_out),   64'd0);
    check("srst_sel_err",   64'(sel_err),   64'd0);
    check("srst_err_count", 64'(err_count), 64'd0);
    check("srst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    // counter restarts from zero after reset
    out_ready = 1'b1;
    issue(2'd3, 32'h1, 32'h2, 32'h3, 32'h0);
    issue(2'd0, 32'h1, 32'h2, 32'h3, 32'h1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
